// File: rtl/baccarat_pkg.sv
// Shared baccarat types, rank constants, slot indices and 7-segment glyphs.
// Imported by the datapath, the card7seg decoder and the game state machine.
package baccarat_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t RANK_EMPTY = 4'd0;
  localparam card_t RANK_A     = 4'd1;
  localparam card_t RANK_K     = 4'd13;

  localparam int unsigned NUM_SLOTS = 6;

  typedef enum logic [2:0] {P1, P2, P3, D1, D2, D3} slot_e;

  // Active-high glyphs, bit order {g, f, e, d, c, b, a}.
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_J     = 7'b0011110;
  localparam logic [6:0] GLYPH_Q     = 7'b1100111;
  localparam logic [6:0] GLYPH_K     = 7'b1110110;

  // Baccarat point value: pips count face value, tens and court cards count zero.
  function automatic score_t card_value(card_t card);
    if (card >= RANK_A && card <= 4'd9) begin
      return card;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/card7seg.sv
// Combinational card rank to 7-segment decoder; blank for empty or illegal ranks.
// SEG_ACTIVE_LOW selects the output polarity.
module card7seg
  import baccarat_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] card,
  output logic [6:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph = GLYPH_BLANK;
    case (card)
      4'd1:    glyph = GLYPH_A;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      4'd10:   glyph = GLYPH_0;
      4'd11:   glyph = GLYPH_J;
      4'd12:   glyph = GLYPH_Q;
      4'd13:   glyph = GLYPH_K;
      default: glyph = GLYPH_BLANK;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card-holding datapath: six rank slots, mod-10 hand scores, sticky load error.
// Define BACCARAT_DATAPATH_SEG_EN to add HEX0-HEX5 rank displays.
module baccarat_datapath
  import baccarat_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic       pcard3_valid,
  output logic [2:0] cards_dealt,
  output logic       load_err
`ifdef BACCARAT_DATAPATH_SEG_EN
  ,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
`endif
);

  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] full_vec;
  card_t                slot_q [NUM_SLOTS];
  card_t                slot_d [NUM_SLOTS];
  logic [2:0]           dealt_q, dealt_d;
  logic                 err_q, err_d;
  logic                 multi_load, target_full, card_ok, load_legal;

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

  always_comb begin
    full_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      full_vec[i] = (slot_q[i] != RANK_EMPTY);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more strobes are high.
  assign multi_load  = |(load_vec & (load_vec - 6'd1));
  assign target_full = |(load_vec & full_vec);
  assign card_ok     = (new_card >= RANK_A) && (new_card <= RANK_K);
  assign load_legal  = !multi_load && !target_full && card_ok;

  always_comb begin
    slot_d  = slot_q;
    dealt_d = dealt_q;
    err_d   = err_q;
    if (load_vec != '0) begin
      if (load_legal) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (load_vec[i]) slot_d[i] = new_card;
        end
        if (dealt_q < 3'd6) dealt_d = dealt_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= RANK_EMPTY;
      dealt_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      dealt_q <= dealt_d;
      err_q   <= err_d;
    end
  end

  // Three point values of at most 9 sum to at most 27, so two subtractions suffice.
  function automatic score_t mod10(logic [4:0] sum);
    logic [4:0] s;
    s = sum;
    if (s >= 5'd10) s = s - 5'd10;
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  logic [4:0] psum, dsum;

  assign psum = {1'b0, card_value(slot_q[P1])} + {1'b0, card_value(slot_q[P2])}
              + {1'b0, card_value(slot_q[P3])};
  assign dsum = {1'b0, card_value(slot_q[D1])} + {1'b0, card_value(slot_q[D2])}
              + {1'b0, card_value(slot_q[D3])};

  assign pscore       = mod10(psum);
  assign dscore       = mod10(dsum);
  assign pcard3       = card_value(slot_q[P3]);
  assign pcard3_valid = full_vec[P3];
  assign cards_dealt  = dealt_q;
  assign load_err     = err_q;

`ifdef BACCARAT_DATAPATH_SEG_EN
  logic [6:0] hex [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_seg
    card7seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_card7seg (
      .card(slot_q[g]),
      .seg (hex[g])
    );
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
`else
  logic unused_seg_polarity;
  assign unused_seg_polarity = SEG_ACTIVE_LOW;
`endif

endmodule
